// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: CPU single accesses (port A) and DMA bursts (port B) share one memory.
// Latency: ack two cycles after the IDLE sampling cycle; single transfer 3 cycles, burst beat every 2 cycles.
// Backpressure: requesters hold req/inputs until ack (A) or done (B); a loser simply waits in IDLE.
module dm_arbiter #(
  parameter int AW    = 8,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,

  // CPU port: one word per request
  input  logic             a_req,
  input  logic             a_wen,
  input  logic [AW-1:0]    a_addr,
  input  logic [31:0]      a_wdata,
  output logic             a_ack,
  output logic [31:0]      a_rdata,

  // DMA port: burst of b_len words starting at b_addr
  input  logic             b_req,
  input  logic             b_wen,
  input  logic [AW-1:0]    b_addr,
  input  logic [LEN_W-1:0] b_len,
  input  logic [31:0]      b_wdata,
  output logic             b_ack,
  output logic [31:0]      b_rdata,
  output logic             b_done,

  // data memory (combinational read, write on rising edge)
  output logic             mem_wen,
  output logic [AW-1:0]    mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [AW-1:0]    ADDR_ONE = AW'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;

  // port granted most recently; B after reset so A wins the first tie
  logic             last_grant;
  // port owning the transfer currently in ACCESS/RESP
  logic             owner;

  // transfer parameters captured in IDLE (and re-captured between burst beats)
  logic             lat_wen;
  logic [AW-1:0]    lat_addr;
  logic [31:0]      lat_wdata;
  // beats still to do after the current one
  logic [LEN_W-1:0] remaining;

  logic             any_req;
  logic             grant_b;
  logic             more_beats;
  logic             burst_continue;
  logic [LEN_W-1:0] first_remaining;

  // Arbitration and burst bookkeeping decode
  always_comb begin
    any_req  = a_req | b_req;
    grant_b  = 1'b0;
    if (a_req && b_req) begin
      grant_b = (last_grant == PORT_A);
    end else begin
      grant_b = b_req;
    end
    more_beats     = (remaining != '0);
    burst_continue = (state == RESP) && (owner == PORT_B) && more_beats;
    // zero length is treated as a single beat
    first_remaining = (b_len == '0) ? '0 : (b_len - LEN_ONE);
  end

  // Next-state logic: bursts chain RESP->ACCESS without passing through IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = any_req ? ACCESS : IDLE;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = burst_continue ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant capture and transfer-parameter latching
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_B;
      owner      <= PORT_A;
      lat_wen    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      remaining  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= grant_b;
            owner      <= grant_b;
            lat_wen    <= grant_b ? b_wen   : a_wen;
            lat_addr   <= grant_b ? b_addr  : a_addr;
            lat_wdata  <= grant_b ? b_wdata : a_wdata;
            remaining  <= grant_b ? first_remaining : '0;
          end
        end
        RESP: begin
          // next beat: address wraps naturally at 2^AW, DMA has already presented new data
          if (burst_continue) begin
            lat_addr  <= lat_addr + ADDR_ONE;
            lat_wdata <= b_wdata;
            remaining <= remaining - LEN_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Read data capture on the ACCESS exit edge; writes leave rdata untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (state == ACCESS && !lat_wen) begin
      if (owner == PORT_A) begin
        a_rdata <= mem_rdata;
      end else begin
        b_rdata <= mem_rdata;
      end
    end
  end

  // Handshake and memory outputs; rst gates them so an in-flight write is dropped immediately
  always_comb begin
    a_ack     = !rst && (state == RESP) && (owner == PORT_A);
    b_ack     = !rst && (state == RESP) && (owner == PORT_B);
    b_done    = b_ack && !more_beats;
    mem_wen   = !rst && (state == ACCESS) && lat_wen;
    mem_addr  = rst ? '0 : lat_addr;
    mem_wdata = rst ? '0 : lat_wdata;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a 256-word behavioural data memory.
// Latency: checks ack timing cycle by cycle against hand-derived schedules.
// Backpressure: requests are held until ack/done exactly as a CPU/DMA would.
module tb_dm_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req, a_wen;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic        a_ack;
  logic [31:0] a_rdata;
  logic        b_req, b_wen;
  logic [7:0]  b_addr;
  logic [4:0]  b_len;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic [31:0] b_rdata;
  logic        b_done;
  logic        mem_wen;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];
  logic        mem_init;
  int          wen_cnt;

  int tests;
  int fails;

  dm_arbiter #(.AW(8), .LEN_W(5)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_len(b_len), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_done(b_done),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: preload pattern A500_00xx with word 5 = 1234ABCD, write on rising edge
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= (i == 5) ? 32'h1234ABCD : (32'hA5000000 | 32'(i));
      end
      wen_cnt <= 0;
    end else if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
      wen_cnt       <= wen_cnt + 1;
    end
  end

  assign mem_rdata = mem[mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_ack"},     32'(a_ack),     32'd0);
    chk({tag, "_b_ack"},     32'(b_ack),     32'd0);
    chk({tag, "_b_done"},    32'(b_done),    32'd0);
    chk({tag, "_a_rdata"},   a_rdata,        32'd0);
    chk({tag, "_b_rdata"},   b_rdata,        32'd0);
    chk({tag, "_mem_wen"},   32'(mem_wen),   32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
  endtask

  // Single CPU access from an IDLE arbiter; returns in the ack cycle with a_req dropped
  task automatic do_a(input logic wen, input logic [7:0] addr, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_rd, input string tag);
    int  n;
    logic seen;
    a_req = 1'b1; a_wen = wen; a_addr = addr; a_wdata = wd;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      step();
      n++;
      if (a_ack) seen = 1'b1;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    if (!wen) chk({tag, "_rdata"}, a_rdata, exp_rd);
    a_req = 1'b0;
  endtask

  initial begin
    int          cnt0;
    logic [7:0]  ea;
    tests = 0; fails = 0;
    rst = 1'b1; mem_init = 1'b1;
    a_req = 1'b0; a_wen = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_wen = 1'b0; b_addr = '0; b_len = '0; b_wdata = '0;

    // reset values
    step();
    mem_init = 1'b0;
    chk_reset_vals("rst0");
    step();
    rst = 1'b0;

    // A read of word 5
    cnt0 = wen_cnt;
    do_a(1'b0, 8'h05, 32'h0, 2, 32'h1234ABCD, "a_rd5");
    step();
    chk("a_rd5_ack_low", 32'(a_ack), 32'd0);
    chk("a_rd5_no_wen", 32'(wen_cnt - cnt0), 32'd0);

    // A write then read back
    cnt0 = wen_cnt;
    do_a(1'b1, 8'h10, 32'hDEADBEEF, 2, 32'h0, "a_wr10");
    chk("a_wr_rdata_kept", a_rdata, 32'h1234ABCD);
    step();
    do_a(1'b0, 8'h10, 32'h0, 2, 32'hDEADBEEF, "a_rd10");
    chk("a_wr_one_pulse", 32'(wen_cnt - cnt0), 32'd1);
    step();

    // Contention after reset: A, B, A, B with 3 cycles per transfer
    rst = 1'b1;
    step();
    chk_reset_vals("rst1");
    rst = 1'b0;
    a_req = 1'b1; a_wen = 1'b0; a_addr = 8'h05;
    b_req = 1'b1; b_wen = 1'b0; b_addr = 8'h20; b_len = 5'd1;
    for (int s = 1; s <= 11; s++) begin
      step();
      chk($sformatf("cont_a_ack_s%0d", s), 32'(a_ack), 32'((s == 2) || (s == 8)));
      chk($sformatf("cont_b_ack_s%0d", s), 32'(b_ack), 32'((s == 5) || (s == 11)));
      if (s == 2) chk("cont_a_rdata", a_rdata, 32'h1234ABCD);
      if (s == 4) chk("cont_b_access_addr", 32'(mem_addr), 32'h20);
      if (s == 5) begin
        chk("cont_b_rdata", b_rdata, 32'hA5000020);
        chk("cont_b_done", 32'(b_done), 32'd1);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    step();

    // Write burst wrapping FE,FF,00,01 with A arriving mid-burst
    cnt0 = wen_cnt;
    b_req = 1'b1; b_wen = 1'b1; b_addr = 8'hFE; b_len = 5'd4; b_wdata = 32'd1;
    for (int s = 1; s <= 12; s++) begin
      step();
      chk($sformatf("bw_b_ack_s%0d", s), 32'(b_ack), 32'((s == 2) || (s == 4) || (s == 6) || (s == 8)));
      chk($sformatf("bw_b_done_s%0d", s), 32'(b_done), 32'(s == 8));
      chk($sformatf("bw_a_ack_s%0d", s), 32'(a_ack), 32'(s == 11));
      if ((s % 2 == 1) && s <= 7) begin
        ea = 8'hFE + 8'((s - 1) / 2);
        chk($sformatf("bw_addr_s%0d", s), 32'(mem_addr), 32'(ea));
        chk($sformatf("bw_wdata_s%0d", s), mem_wdata, 32'((s + 1) / 2));
        chk($sformatf("bw_wen_s%0d", s), 32'(mem_wen), 32'd1);
      end
      if (s == 10) begin
        chk("bw_a_access_addr", 32'(mem_addr), 32'h05);
        chk("bw_a_access_wen", 32'(mem_wen), 32'd0);
      end
      if (b_ack && s < 8) b_wdata = b_wdata + 32'd1;
      if (s == 8) b_req = 1'b0;
      if (s == 3) begin
        a_req = 1'b1; a_wen = 1'b0; a_addr = 8'h05;
      end
      if (a_ack) a_req = 1'b0;
    end
    chk("bw_mem_FE", mem[8'hFE], 32'd1);
    chk("bw_mem_FF", mem[8'hFF], 32'd2);
    chk("bw_mem_00", mem[8'h00], 32'd3);
    chk("bw_mem_01", mem[8'h01], 32'd4);
    chk("bw_mem_02", mem[8'h02], 32'hA5000002);
    chk("bw_pulses", 32'(wen_cnt - cnt0), 32'd4);
    chk("bw_b_rdata_kept", b_rdata, 32'hA5000020);

    // Zero-length read: a single beat with ack and done together
    b_req = 1'b1; b_wen = 1'b0; b_addr = 8'h05; b_len = 5'd0;
    for (int s = 1; s <= 4; s++) begin
      step();
      chk($sformatf("b0_ack_s%0d", s), 32'(b_ack), 32'(s == 2));
      chk($sformatf("b0_done_s%0d", s), 32'(b_done), 32'(s == 2));
      if (s == 2) begin
        chk("b0_rdata", b_rdata, 32'h1234ABCD);
        b_req = 1'b0;
      end
    end

    // Reset during ACCESS of beat 2 of a 4-beat write burst
    b_req = 1'b1; b_wen = 1'b1; b_addr = 8'h40; b_len = 5'd4; b_wdata = 32'h11;
    step();
    step();
    chk("rb_beat1_ack", 32'(b_ack), 32'd1);
    b_wdata = 32'h22;
    step();
    chk("rb_beat2_wen", 32'(mem_wen), 32'd1);
    chk("rb_beat2_addr", 32'(mem_addr), 32'h41);
    rst = 1'b1;
    #1;
    chk("rb_wen_gated", 32'(mem_wen), 32'd0);
    step();
    chk_reset_vals("rst2");
    chk("rb_mem_40", mem[8'h40], 32'h11);
    chk("rb_mem_41", mem[8'h41], 32'hA5000041);
    rst = 1'b0; b_req = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      step();
      chk($sformatf("rb_after_ack_s%0d", s), 32'(b_ack), 32'd0);
      chk($sformatf("rb_after_done_s%0d", s), 32'(b_done), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
